muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit, the sequential counterpart of the single-cycle ALU in the execute stage. It takes the same operand pair (srcA, srcB) and an operation code, runs a radix-2 shift-add multiply or restoring divide over 32 cycles, and returns one 32-bit result. A start/busy/done handshake lets the controller stall the pipeline until the result is ready.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_sign_fix.sv | 15 +
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared operation codes, state encoding and helpers for the multiply/divide unit
package md_pkg;

   // Operation codes follow the RV32M funct3 encoding
   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // One iteration per operand bit
   localparam int MD_ITER = 32;

   // srcA is treated as signed for every op except the fully unsigned ones
   function automatic logic md_signed_a(input logic [2:0] op);
      return !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
   endfunction

   // srcB is signed only for the fully signed ops (MULHSU treats it unsigned)
   function automatic logic md_signed_b(input logic [2:0] op);
      return (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negate
module md_sign_fix #(
   parameter int W = 64
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   // Negate when requested, otherwise pass the value through unchanged
   always_comb begin
      res_o = neg_i ? (~val_i + W'(1)) : val_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
module muldiv_unit
   import md_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      MDControl,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] MDResult
);

   md_state_e   state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [64:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic [2:0]  op_q, op_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic [31:0] result_q, result_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        in_sign_a, in_sign_b;
   logic [31:0] mag_a, mag_b;
   logic        div_zero, div_ovf;

   logic        is_div;
   logic [32:0] srem;
   logic [32:0] add_a, add_b;
   logic [33:0] add_res;
   logic        no_borrow;
   logic [64:0] iter_acc;
   logic [63:0] fix_val, fix_res;
   logic        fix_neg;
   logic [31:0] fin_res;

   assign in_sign_a = md_signed_a(MDControl) & srcA[31];
   assign in_sign_b = md_signed_b(MDControl) & srcB[31];

   assign div_zero = MDControl[2] && (srcB == 32'd0);
   assign div_ovf  = (MDControl == MD_DIV || MDControl == MD_REM) &&
                     (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

   // Operand magnitudes: the core iterates on unsigned values only
   md_sign_fix #(.W(32)) u_fix_a (
      .val_i (srcA),
      .neg_i (in_sign_a),
      .res_o (mag_a)
   );

   md_sign_fix #(.W(32)) u_fix_b (
      .val_i (srcB),
      .neg_i (in_sign_b),
      .res_o (mag_b)
   );

   // Result fix-up applied to the value produced by the final iteration
   md_sign_fix #(.W(64)) u_fix_res (
      .val_i (fix_val),
      .neg_i (fix_neg),
      .res_o (fix_res)
   );

   // One iteration of shift-add multiply or restoring divide on the shared {hi,lo} register
   always_comb begin
      is_div    = op_q[2];
      srem      = acc_q[63:31];
      add_a     = is_div ? srem : acc_q[64:32];
      add_b     = is_div ? ~{1'b0, opnd_q} : (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
      add_res   = {1'b0, add_a} + {1'b0, add_b} + {33'd0, is_div};
      no_borrow = add_res[33];
      if (is_div) begin
         iter_acc = {1'b0, (no_borrow ? add_res[31:0] : srem[31:0]), acc_q[30:0], no_borrow};
      end else begin
         iter_acc = {1'b0, add_res[32:0], acc_q[31:1]};
      end
      if (!is_div) begin
         fix_val = iter_acc[63:0];
         fix_neg = sign_a_q ^ sign_b_q;
      end else if (op_q[1]) begin
         fix_val = {32'd0, iter_acc[63:32]};
         fix_neg = sign_a_q;
      end else begin
         fix_val = {32'd0, iter_acc[31:0]};
         fix_neg = sign_a_q ^ sign_b_q;
      end
   end

   // Next-state logic: FSM, iteration counter, operand capture and result selection
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      result_d = result_q;
      fin_res  = (op_q == MD_MUL || is_div) ? fix_res[31:0] : fix_res[63:32];

      case (state_q)
         MD_CALC: begin
            acc_d = iter_acc;
            if (cnt_q == 6'(MD_ITER - 1)) begin
               cnt_d    = 6'd0;
               state_d  = MD_DONE;
               result_d = fin_res;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end
         MD_DONE: state_d = MD_IDLE;
         default: state_d = state_q;
      endcase

      // Accept a new request from IDLE or DONE; requests during CALC are dropped
      if (start && !busy_q) begin
         op_d     = MDControl;
         sign_a_d = in_sign_a;
         sign_b_d = in_sign_b;
         cnt_d    = 6'd0;
         if (MDControl[2]) begin
            opnd_d = mag_b;
            acc_d  = {33'd0, mag_a};
         end else begin
            opnd_d = mag_a;
            acc_d  = {33'd0, mag_b};
         end
         if (div_zero) begin
            state_d  = MD_DONE;
            result_d = MDControl[1] ? srcA : 32'hFFFF_FFFF;
         end else if (div_ovf) begin
            state_d  = MD_DONE;
            result_d = MDControl[1] ? 32'd0 : 32'h8000_0000;
         end else begin
            state_d = MD_CALC;
         end
      end

      busy_d = (state_d == MD_CALC);
      done_d = (state_d == MD_DONE);
   end

   // State and output registers; reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MD_IDLE;
         cnt_q    <= 6'd0;
         acc_q    <= 65'd0;
         opnd_q   <= 32'd0;
         op_q     <= 3'd0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         result_q <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign MDResult = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against a behavioural model
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  md_control;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] md_result;

   int n_checks = 0;
   int n_errors = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .MDControl (md_control),
      .srcA      (src_a),
      .srcB      (src_b),
      .busy      (busy),
      .done      (done),
      .MDResult  (md_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference results straight from the RV32M arithmetic definitions
   function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ub_s;
      logic        [63:0] p;
      logic signed [31:0] as, bs, q;
      sa   = {{32{a[31]}}, a};
      sb   = {{32{b[31]}}, b};
      ub_s = {32'd0, b};
      as   = a;
      bs   = b;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub_s; return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = as / bs; return q;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = as % bs; return q;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2] && b == 0) return 1'b1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      return 1'b0;
   endfunction

   // Model: cycles remaining until done (33 normal, 1 special); busy while >1, done at 1
   int          m_cnt  = 0;
   logic [31:0] m_res  = '0;
   logic [31:0] m_pend = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_res  <= '0;
         m_pend <= '0;
      end else if (start && m_cnt <= 1) begin
         m_pend <= ref_md(md_control, src_a, src_b);
         if (is_special(md_control, src_a, src_b)) begin
            m_cnt <= 1;
            m_res <= ref_md(md_control, src_a, src_b);
         end else begin
            m_cnt <= 33;
         end
      end else begin
         m_cnt <= (m_cnt > 0) ? m_cnt - 1 : 0;
         if (m_cnt == 2) m_res <= m_pend;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      chk("cyc_busy", busy, m_cnt > 1);
      chk("cyc_done", done, m_cnt == 1);
      chk("cyc_result", md_result, m_res);
   end

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int   lat;
      logic saw_busy;
      chk({name, "_model"}, ref_md(op, a, b), exp);
      @(posedge clk); #1;
      md_control = op; src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      saw_busy = busy;
      while (!done && lat < 45) begin
         @(posedge clk); #1;
         lat++;
         saw_busy = saw_busy | busy;
      end
      chk({name, "_done"}, done, 1);
      chk({name, "_latency"}, lat, exp_lat);
      chk({name, "_result"}, md_result, exp);
      if (exp_lat == 1) chk({name, "_busy_seen"}, saw_busy, 0);
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int k;
      bit b2b;
      rst_n = 1'b0; start = 1'b0; md_control = '0; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_result", md_result, 0);
      rst_n = 1'b1;

      run_op("mul_7_m3",     3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      run_op("mulh_7_m3",    3'd1, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      run_op("mulhu_7_m3",   3'd3, 32'h7, 32'hFFFF_FFFD, 32'h0000_0006, 33);
      run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
      run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
      run_op("divu_big",     3'd5, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
      run_op("remu_big",     3'd7, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33);
      run_op("div_zero",     3'd4, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
      run_op("rem_zero",     3'd6, 32'h1234, 32'h0, 32'h0000_1234, 1);
      run_op("divu_zero",    3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
      run_op("remu_zero",    3'd7, 32'h1234, 32'h0, 32'h0000_1234, 1);
      run_op("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // start pulsed mid-CALC is ignored
      @(posedge clk); #1;
      md_control = 3'd0; src_a = 32'h7; src_b = 32'hFFFF_FFFD; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      repeat (9) begin @(posedge clk); #1; lat++; end
      md_control = 3'd5; src_a = 32'h99; src_b = 32'h3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat++;
      while (!done && lat < 45) begin @(posedge clk); #1; lat++; end
      chk("ignore_done", done, 1);
      chk("ignore_latency", lat, 33);
      chk("ignore_result", md_result, 32'hFFFF_FFEB);

      // start held during DONE is accepted back-to-back
      @(posedge clk); #1;
      md_control = 3'd5; src_a = 32'hFFFF_FFFF; src_b = 32'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      while (!done && lat < 45) begin @(posedge clk); #1; lat++; end
      chk("b2b_first", md_result, 32'h0FFF_FFFF);
      md_control = 3'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      chk("b2b_busy", busy, 1);
      while (!done && lat < 45) begin @(posedge clk); #1; lat++; end
      chk("b2b_latency", lat, 33);
      chk("b2b_second", md_result, 32'h0000_000F);

      // asynchronous reset mid-CALC
      @(posedge clk); #1;
      md_control = 3'd0; src_a = 32'h1234_5678; src_b = 32'h9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) begin @(posedge clk); #1; end
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset_busy", busy, 0);
      chk("areset_done", done, 0);
      chk("areset_result", md_result, 0);
      repeat (2) begin @(posedge clk); #1; chk("areset_no_done", done, 0); end
      rst_n = 1'b1;
      repeat (20) begin @(posedge clk); #1; chk("post_reset_no_done", done, 0); end
      run_op("mul_3_5", 3'd0, 32'h3, 32'h5, 32'h0000_000F, 33);

      // randomized traffic with stray starts and back-to-back requests
      b2b = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!b2b) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         md_control = 3'($urandom_range(0, 7));
         src_a = rnd_opnd();
         src_b = rnd_opnd();
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         k = 1;
         while (!done && k < 40) begin
            if ($urandom_range(0, 9) == 0) begin
               start = 1'b1;
               src_a = $urandom;
               src_b = $urandom;
               md_control = 3'($urandom_range(0, 7));
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
         end
         start = 1'b0;
         chk("rand_done", done, 1);
         b2b = ($urandom_range(0, 3) == 0);
      end

      repeat (4) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
